pmp_capture: RTL and testbench



---
 rtl/pmp_pkg.sv | 17 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/pmp_capture.sv | 151 +++++++++++++++
 tb/tb_pmp_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// pmp_pkg: shared definitions for the PMP byte-handshake blocks.
//   pmp_state_e - requester FSM states
//   PMP_DATA_W  - width of one transferred byte (also used by the responder side)
package pmp_pkg;

  localparam int PMP_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPACE = 3'd1,
    S_REQ   = 3'd2,
    S_REL   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } pmp_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head.
//   clk, rst_n   - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  - write strobe and data (ignored when full)
//   pop          - consume head entry (ignored when empty)
//   rdata        - head entry, forced to 0 while empty
//   full, empty  - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: contents are only visible through rdata when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pmp_capture.sv
// pmp_capture: requester end of the 8-bit PMP byte handshake.
//   decim_clk, rst_n   - clock, synchronous active-low reset
//   start              - begins a burst of BURST_LEN bytes (dropped while busy)
//   pmp_d0..pmp_d7     - responder data bits, stable while drdy is high
//   pmp_drdy           - asynchronous responder ready
//   pmp_dreq           - registered byte request
//   out_data/valid/ready - capture FIFO drain stream
//   busy, done         - burst in progress / one-cycle end-of-burst pulse
//   timeout_err        - sticky abort flag, cleared by the next accepted start
module pmp_capture
  import pmp_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  decim_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pmp_d0,
  input  logic                  pmp_d1,
  input  logic                  pmp_d2,
  input  logic                  pmp_d3,
  input  logic                  pmp_d4,
  input  logic                  pmp_d5,
  input  logic                  pmp_d6,
  input  logic                  pmp_d7,
  input  logic                  pmp_drdy,
  output logic                  pmp_dreq,
  output logic [PMP_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TONE     = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [7:0]  BURST_INIT = 8'(BURST_LEN);

  pmp_state_e      state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dreq_q, dreq_d;
  logic            terr_q, terr_d;
  logic            drdy_s;
  logic            push, pop, fifo_full, fifo_empty;
  logic [PMP_DATA_W-1:0] cap_byte;

  assign cap_byte = {pmp_d7, pmp_d6, pmp_d5, pmp_d4, pmp_d3, pmp_d2, pmp_d1, pmp_d0};

  // Two-flop synchroniser; the FSM only looks at the second stage.
  assign sync_d = {sync_q[0], pmp_drdy};
  assign drdy_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    terr_d      = terr_q;
    push        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // busy is already low in DONE/ERR, so a start there is honoured too.
        state_d = S_IDLE;
        if (start) begin
          state_d     = S_SPACE;
          remaining_d = BURST_INIT;
          terr_d      = 1'b0;
        end
      end
      S_SPACE: begin
        // Only request a byte when it is guaranteed a slot.
        if (!fifo_full) begin
          state_d = S_REQ;
          timer_d = '0;
        end
      end
      S_REQ: begin
        if (drdy_s) begin
          push        = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d     = S_REL;
          timer_d     = '0;
        end else if (timer_q == TMAX) begin
          state_d = S_ERR;
          terr_d  = 1'b1;
        end else begin
          timer_d = timer_q + TONE;
        end
      end
      S_REL: begin
        if (!drdy_s) begin
          state_d = (remaining_q != 8'd0) ? S_SPACE : S_DONE;
        end else if (timer_q == TMAX) begin
          state_d = S_ERR;
          terr_d  = 1'b1;
        end else begin
          timer_d = timer_q + TONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Request is a registered decode of the next state, so it tracks REQ exactly.
    dreq_d = (state_d == S_REQ);
  end

  always_ff @(posedge decim_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      dreq_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      dreq_q      <= dreq_d;
      terr_q      <= terr_d;
    end
  end

  assign pop = out_valid && out_ready;

  sync_fifo #(
    .WIDTH(PMP_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (decim_clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(cap_byte),
    .pop  (pop),
    .rdata(out_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign pmp_dreq    = dreq_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q == S_SPACE) || (state_q == S_REQ) || (state_q == S_REL);
  assign done        = (state_q == S_DONE) || (state_q == S_ERR);

endmodule

// File: tb/tb_pmp_capture.sv
// Bench for pmp_capture: responder model pushes every byte it drives into a
// scoreboard queue; the consumer pops and compares on each stream handshake.
module tb_pmp_capture;

  localparam int BL = 20;
  localparam int TO = 16;
  localparam int FD = 16;

  logic       decim_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       drdy      = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] d_byte    = 8'h00;
  logic       pmp_dreq, out_valid, busy, done, timeout_err;
  logic [7:0] out_data;

  int n_chk = 0, n_err = 0;
  int rsp_mode = 0;   // 0 answer, 1 never answer, 2 hold drdy high after a byte
  bit rsp_rand = 1'b0;
  int rdy_mode = 0;   // 0 low, 1 high, 2 random
  int n_rsp = 0, done_cnt = 0, rx_cnt = 0, pat = 1;
  logic [7:0] sbq[$];

  always #5 decim_clk = ~decim_clk;

  pmp_capture #(.BURST_LEN(BL), .TIMEOUT(TO), .FIFO_DEPTH(FD)) dut (
    .decim_clk(decim_clk), .rst_n(rst_n), .start(start),
    .pmp_d0(d_byte[0]), .pmp_d1(d_byte[1]), .pmp_d2(d_byte[2]), .pmp_d3(d_byte[3]),
    .pmp_d4(d_byte[4]), .pmp_d5(d_byte[5]), .pmp_d6(d_byte[6]), .pmp_d7(d_byte[7]),
    .pmp_drdy(drdy), .pmp_dreq(pmp_dreq), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge decim_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int base, string tag);
    int n = 0;
    while (done_cnt == base && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, done_cnt, base + 1);
  endtask

  task automatic drain(string tag);
    int n = 0;
    rdy_mode = 1;
    while ((sbq.size() != 0 || out_valid) && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, sbq.size(), 0);
  endtask

  // Responder: answers a request after a latency, holds data until dreq drops.
  initial begin : responder
    int lat;
    forever begin
      @(negedge decim_clk);
      if (drdy && !pmp_dreq && rsp_mode != 2) begin
        drdy = 1'b0;
      end else if (rst_n && pmp_dreq && !drdy && rsp_mode != 1) begin
        lat = rsp_rand ? int'($urandom_range(0, 10)) : 3;
        repeat (lat) @(negedge decim_clk);
        d_byte = rsp_rand ? 8'($urandom) : 8'(pat * 17);
        pat++;
        drdy = 1'b1;
        sbq.push_back(d_byte);
        n_rsp++;
      end
    end
  end

  // Consumer: drives out_ready and checks every accepted byte.
  initial begin : consumer
    logic [7:0] exp_b;
    forever begin
      @(negedge decim_clk);
      out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      if (rst_n && done) begin
        done_cnt++;
        chk("busy_low_with_done", busy, 0);
      end
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_extra_byte", sbq.size(), 1);
        else begin
          exp_b = sbq.pop_front();
          chk("sb_byte", out_data, exp_b);
        end
        rx_cnt++;
      end
    end
  end

  initial begin : main
    int base, rx0, rsp0, n, hi;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_dreq", pmp_dreq, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // Nominal burst; a second start mid-burst must be ignored.
    rdy_mode = 1; rsp0 = n_rsp; rx0 = rx_cnt; base = done_cnt;
    pulse_start();
    chk("start_busy", busy, 1);
    tick();
    chk("start_dreq", pmp_dreq, 1);
    repeat (5) tick();
    pulse_start();
    wait_done(base, "nom_done");
    chk("nom_terr", timeout_err, 0);
    chk("nom_bytes", n_rsp - rsp0, BL);
    repeat (5) tick();
    chk("nom_single_done", done_cnt, base + 1);
    drain("nom_drain");
    chk("nom_rx", rx_cnt - rx0, BL);

    // Backpressure: stall at FIFO_DEPTH bytes, resume when drained.
    rdy_mode = 0; rsp0 = n_rsp; base = done_cnt;
    pulse_start();
    repeat (300) tick();
    chk("bp_bytes", n_rsp - rsp0, FD);
    chk("bp_dreq", pmp_dreq, 0);
    chk("bp_busy", busy, 1);
    chk("bp_valid", out_valid, 1);
    rdy_mode = 1;
    wait_done(base, "bp_done");
    chk("bp_total", n_rsp - rsp0, BL);
    drain("bp_drain");

    // Timeout in REQ.
    rsp_mode = 1; base = done_cnt;
    pulse_start();
    n = 0;
    while (!pmp_dreq && n < 20) begin tick(); n++; end
    hi = 0;
    while (pmp_dreq && hi < 100) begin tick(); hi++; end
    chk("to_dreq_cycles", hi, TO);
    wait_done(base, "to_done");
    chk("to_terr", timeout_err, 1);
    chk("to_empty", out_valid, 0);
    rsp_mode = 0; base = done_cnt;
    pulse_start();
    chk("to_clear", timeout_err, 0);
    wait_done(base, "to_next_done");
    chk("to_next_terr", timeout_err, 0);
    drain("to_drain");

    // Stuck release: drdy held high after the first byte.
    rsp_mode = 2; rdy_mode = 0; rsp0 = n_rsp; base = done_cnt;
    pulse_start();
    wait_done(base, "stuck_done");
    chk("stuck_terr", timeout_err, 1);
    chk("stuck_bytes", n_rsp - rsp0, 1);
    chk("stuck_valid", out_valid, 1);
    chk("stuck_data", out_data, (sbq.size() != 0) ? sbq[0] : 8'hxx);

    // Reset mid-REQ with a byte still in the FIFO.
    rsp_mode = 1;
    repeat (3) tick();
    pulse_start();
    n = 0;
    while (!pmp_dreq && n < 20) begin tick(); n++; end
    chk("rst_mid_req", pmp_dreq, 1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_dreq", pmp_dreq, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    sbq.delete();
    rst_n = 1'b1;
    tick();

    // Random data, latency and backpressure.
    rsp_mode = 0; rsp_rand = 1'b1; rdy_mode = 2; rsp0 = n_rsp; rx0 = rx_cnt;
    for (int b = 0; b < 13; b++) begin
      base = done_cnt;
      pulse_start();
      wait_done(base, "rnd_done");
      chk("rnd_terr", timeout_err, 0);
    end
    drain("rnd_drain");
    chk("rnd_sent", n_rsp - rsp0, 13 * BL);
    chk("rnd_rx", rx_cnt - rx0, 13 * BL);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
